h14tx_pkt_scheduler: RTL and testbench
======================================

// Module: h14tx_pkt_scheduler
// PURPOSE
//  Data-island packet scheduler for the HDMI 1.4 TX. Arbitrates NumSrc packet generators
//  (audio sample, ACR, AVI/audio InfoFrame, ...) into the single packet slot of the island
//  serializer, one packet per slot. It emits a Null packet when no source is eligible.
//  Sits between the h14tx_pkt_* generators and the data-island TERC4 encoder.
// PARAMETERS
//  NumSrc        4        number of packet sources (2..8)
//  PrioSrc       0        index of the strict-priority source (audio sample packets)
//  FrameOnceMask 4'b1100  bit i set: source i is sent at most once per frame (InfoFrames)
// PORTS
//  clk          in   1            pixel clock
//  rst          in   1            synchronous, active-high reset
//  frame_start  in   1            one-cycle pulse at start of vertical blank
//  island_slot  in   1            one-cycle pulse: serializer opens a packet slot
//  req          in   NumSrc       per-source level request, held until granted
//  src_header   in   NumSrc x 24  per-source packet header (HB2,HB1,HB0)
//  src_sub      in   NumSrc x 4x56 per-source subpackets 0..3
//  pkt_ready    in   1            serializer accepted the presented packet
//  pkt_valid    out  1            header/sub valid; held until pkt_ready
//  header       out  24           selected packet header
//  sub          out  4x56         selected subpackets
//  grant        out  NumSrc       one-hot, one-cycle pulse on acceptance of a source packet
//  slot_drop    out  1            one-cycle pulse: island_slot arrived while busy
// BEHAVIOUR
//  - Reset: state IDLE; pkt_valid=0, header=0, sub=0, grant=0, slot_drop=0.
//    armed[]=0, rr_ptr=0. Reset mid-EMIT aborts the packet and clears outputs on the next edge.
//  - armed[i] (FrameOnceMask sources only): set on frame_start. Cleared on grant[i].
//    frame_start and grant[i] in the same cycle: frame_start wins (armed stays 1).
//  - eligible[i] = req[i] & (FrameOnceMask[i] ? armed[i] : 1).
//  - FSM IDLE -> ARB -> EMIT -> IDLE:
//    IDLE: island_slot -> ARB.
//    ARB (1 cycle): if eligible[PrioSrc], select PrioSrc. Otherwise select the first eligible
//      index after rr_ptr, cyclically modulo NumSrc, skipping PrioSrc. If none is eligible,
//      select Null. Register header/sub of the selection. Go to EMIT with pkt_valid=1.
//    EMIT: hold header/sub/pkt_valid stable until pkt_ready. On pkt_ready:
//      - pulse grant[sel] (no grant for Null);
//      - update rr_ptr=sel only for a non-prio source;
//      - pkt_valid=0 on the next edge; go to IDLE.
//  - Null packet: header=24'h000000, sub=0.
//  - Latency: island_slot at cycle t -> pkt_valid at t+2. pkt_ready at cycle t+2 ends EMIT.
//  - island_slot in ARB or EMIT is not queued: pulse slot_drop for that cycle.
//  - Selection is frozen in ARB. A req drop during EMIT does not change the packet;
//    the grant is still issued.
//  - Source data is sampled only in ARB. Sources hold header/sub stable while req=1.
// CONFIGURATION
//  H14TX_PKT_SCHED_MISS_EN defined:
//    - adds output miss[NumSrc] (sticky).
//    - miss[i] is set at frame_start if FrameOnceMask[i] & armed[i] & req[i],
//      i.e. the InfoFrame was not sent in the previous frame.
//    - miss is cleared only by rst.
//  Macro not defined: no miss port, no extra logic. Scheduling is identical in both builds.
// TESTING
//  1. Reset held 3 cycles mid-EMIT -> pkt_valid=0, header=0, grant=0 the cycle after rst rises.
//  2. req=4'b0000, island_slot@t:
//     - header=0, sub=0, pkt_valid=1 at t+2;
//     - pkt_ready -> no grant; back to IDLE.
//  3. req=4'b0011, PrioSrc=0, three slots -> grants 0,0,0.
//     Then with req=4'b0010: next slot grants src1.
//  4. frame_start, then req=4'b1100 held, four slots -> grants 2, 3, Null, Null.
//     After the next frame_start, the next slot -> grant 2.
//  5. island_slot during EMIT (pkt_ready held low 40 cycles) ->
//     slot_drop pulses once, header/sub unchanged, single grant.
//  6. MISS_EN build:
//     - req[3]=1 armed, never slotted, frame_start -> miss[3]=1;
//     - miss[3] persists through later grants until rst.

Source files
------------

// File: rtl/h14tx_pkt_scheduler.sv
// Data-island packet scheduler: arbitrates NumSrc packet generators into one serializer slot.
// Optional build macro H14TX_PKT_SCHED_MISS_EN adds the sticky per-source miss_o flags.
module h14tx_pkt_scheduler #(
    parameter int                NumSrc        = 4,
    parameter int                PrioSrc       = 0,
    parameter logic [NumSrc-1:0] FrameOnceMask = 4'b1100
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frame_start_i,
    input  logic                    island_slot_i,
    input  logic [NumSrc-1:0]       req_i,
    input  logic [NumSrc*24-1:0]    src_header_i,
    input  logic [NumSrc*224-1:0]   src_sub_i,
    input  logic                    pkt_ready_i,
    output logic                    pkt_valid_o,
    output logic [23:0]             header_o,
    output logic [223:0]            sub_o,
    output logic [NumSrc-1:0]       grant_o,
    output logic                    slot_drop_o
`ifdef H14TX_PKT_SCHED_MISS_EN
    ,
    output logic [NumSrc-1:0]       miss_o
`endif
);

    localparam int IdxW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic [IdxW-1:0]     sel_q, sel_d;
    logic                null_q, null_d;
    logic [NumSrc-1:0]   armed_q, armed_d;
    logic [23:0]         hdr_q, hdr_d;
    logic [223:0]        sub_q, sub_d;
    logic                valid_q, valid_d;
    logic [NumSrc-1:0]   grant_q, grant_d;

    logic [NumSrc-1:0]   eligible;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_null;

    assign eligible = req_i & (~FrameOnceMask | armed_q);

    // Strict priority first, then round-robin starting just after the last non-prio winner.
    always_comb begin
        int cand;
        cand      = 0;
        pick_idx  = '0;
        pick_null = 1'b1;
        if (eligible[PrioSrc]) begin
            pick_idx  = IdxW'(PrioSrc);
            pick_null = 1'b0;
        end else begin
            for (int k = 1; k <= NumSrc; k++) begin
                cand = (int'(rr_q) + k) % NumSrc;
                if (pick_null && (cand != PrioSrc) && eligible[cand]) begin
                    pick_idx  = IdxW'(cand);
                    pick_null = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        null_d  = null_q;
        armed_d = armed_q;
        hdr_d   = hdr_q;
        sub_d   = sub_q;
        valid_d = valid_q;
        grant_d = '0;

        case (state_q)
            S_IDLE: begin
                if (island_slot_i) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                sel_d   = pick_idx;
                null_d  = pick_null;
                hdr_d   = pick_null ? 24'h0 : src_header_i[int'(pick_idx)*24 +: 24];
                sub_d   = pick_null ? 224'h0 : src_sub_i[int'(pick_idx)*224 +: 224];
                valid_d = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (pkt_ready_i) begin
                    valid_d = 1'b0;
                    hdr_d   = 24'h0;
                    sub_d   = 224'h0;
                    state_d = S_IDLE;
                    if (!null_q) begin
                        grant_d[sel_q] = 1'b1;
                        armed_d[sel_q] = 1'b0;
                        if (int'(sel_q) != PrioSrc) begin
                            rr_d = sel_q;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A frame_start coinciding with a grant re-arms the source.
        if (frame_start_i) begin
            armed_d = armed_d | FrameOnceMask;
        end
        armed_d = armed_d & FrameOnceMask;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            null_q  <= 1'b1;
            armed_q <= '0;
            hdr_q   <= '0;
            sub_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            null_q  <= null_d;
            armed_q <= armed_d;
            hdr_q   <= hdr_d;
            sub_q   <= sub_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
        end
    end

    assign pkt_valid_o = valid_q;
    assign header_o    = hdr_q;
    assign sub_o       = sub_q;
    assign grant_o     = grant_q;
    assign slot_drop_o = island_slot_i & (state_q != S_IDLE) & ~rst_i;

`ifdef H14TX_PKT_SCHED_MISS_EN
    logic [NumSrc-1:0] miss_q, miss_d;

    always_comb begin
        miss_d = miss_q;
        if (frame_start_i) begin
            miss_d = miss_q | (FrameOnceMask & armed_q & req_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_o = miss_q;
`endif

endmodule

// File: tb/tb_h14tx_pkt_scheduler.sv
// Directed self-checking bench for h14tx_pkt_scheduler (default parameters).
// Define H14TX_PKT_SCHED_MISS_EN for both files to also exercise the miss_o flags.
module tb_h14tx_pkt_scheduler;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_start;
    logic           island_slot;
    logic [3:0]     req;
    logic [95:0]    src_header;
    logic [895:0]   src_sub;
    logic           pkt_ready;
    logic           pkt_valid;
    logic [23:0]    header;
    logic [223:0]   sub;
    logic [3:0]     grant;
    logic           slot_drop;
`ifdef H14TX_PKT_SCHED_MISS_EN
    logic [3:0]     miss;
`endif

    logic [23:0]    hdr_t [4];
    logic [223:0]   sub_t [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign src_header = {hdr_t[3], hdr_t[2], hdr_t[1], hdr_t[0]};
    assign src_sub    = {sub_t[3], sub_t[2], sub_t[1], sub_t[0]};

    h14tx_pkt_scheduler dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (frame_start),
        .island_slot_i (island_slot),
        .req_i         (req),
        .src_header_i  (src_header),
        .src_sub_i     (src_sub),
        .pkt_ready_i   (pkt_ready),
        .pkt_valid_o   (pkt_valid),
        .header_o      (header),
        .sub_o         (sub),
        .grant_o       (grant),
        .slot_drop_o   (slot_drop)
`ifdef H14TX_PKT_SCHED_MISS_EN
        ,
        .miss_o        (miss)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full slot transaction; src < 0 means a Null packet is expected.
    task automatic slot_txn(input string tag, input int src);
        logic [23:0]  eh;
        logic [223:0] es;
        logic [3:0]   eg;
        if (src < 0) begin
            eh = '0; es = '0; eg = '0;
        end else begin
            eh = hdr_t[src]; es = sub_t[src]; eg = 4'(1 << src);
        end
        island_slot = 1'b1;
        step();
        island_slot = 1'b0;
        chk({tag, "_t1_valid"}, 256'(pkt_valid), 256'(1'b0));
        step();
        chk({tag, "_t2_valid"}, 256'(pkt_valid), 256'(1'b1));
        chk({tag, "_header"},   256'(header), 256'(eh));
        chk({tag, "_sub"},      256'(sub), 256'(es));
        pkt_ready = 1'b1;
        step();
        pkt_ready = 1'b0;
        chk({tag, "_valid_off"}, 256'(pkt_valid), 256'(1'b0));
        chk({tag, "_grant"},     256'(grant), 256'(eg));
        step();
        chk({tag, "_grant_off"}, 256'(grant), 256'(4'b0000));
    endtask

    initial begin
        int drops;
        int hdr_bad;
        int gcount;
        logic [7:0] b;

        for (int i = 0; i < 4; i++) begin
            b = 8'h10 + 8'(i);
            hdr_t[i] = {b, b, b};
            b = 8'hA0 + 8'(i);
            sub_t[i] = {28{b}};
        end
        rst = 1'b1; frame_start = 1'b0; island_slot = 1'b0; req = 4'b0000; pkt_ready = 1'b0;
        step(); step();
        chk("rst_valid",  256'(pkt_valid), 256'(1'b0));
        chk("rst_header", 256'(header), 256'(24'h0));
        chk("rst_sub",    256'(sub), 256'(224'h0));
        chk("rst_grant",  256'(grant), 256'(4'b0000));
        chk("rst_drop",   256'(slot_drop), 256'(1'b0));
        rst = 1'b0;
        step();

        // Nobody eligible: Null packet, no grant
        req = 4'b0000;
        slot_txn("null", -1);

        // Strict priority wins while requesting, then round-robin picks src1
        req = 4'b0011;
        slot_txn("prio_a", 0);
        slot_txn("prio_b", 0);
        slot_txn("prio_c", 0);
        req = 4'b0010;
        slot_txn("rr_src1", 1);

        // Reset held mid-EMIT aborts the packet
        island_slot = 1'b1;
        step();
        island_slot = 1'b0;
        step();
        chk("abort_pre_valid", 256'(pkt_valid), 256'(1'b1));
        rst = 1'b1;
        step();
        chk("abort_valid",  256'(pkt_valid), 256'(1'b0));
        chk("abort_header", 256'(header), 256'(24'h0));
        chk("abort_grant",  256'(grant), 256'(4'b0000));
        step(); step();
        rst = 1'b0;
        req = 4'b0000;
        step();
        chk("abort_post_valid", 256'(pkt_valid), 256'(1'b0));

        // Once-per-frame sources
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 4'b1100;
        slot_txn("frm_a", 2);
        slot_txn("frm_b", 3);
        slot_txn("frm_c", -1);
        slot_txn("frm_d", -1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        slot_txn("frm_e", 2);

        // Slot arriving while busy is dropped, packet untouched
        req = 4'b0010;
        island_slot = 1'b1;
        step();
        island_slot = 1'b0;
        step();
        chk("busy_valid",  256'(pkt_valid), 256'(1'b1));
        chk("busy_header", 256'(header), 256'(hdr_t[1]));
        drops = 0;
        hdr_bad = 0;
        for (int c = 0; c < 40; c++) begin
            island_slot = (c == 10);
            #1;
            if (slot_drop) drops++;
            if (header !== hdr_t[1] || sub !== sub_t[1] || pkt_valid !== 1'b1) hdr_bad++;
            step();
        end
        island_slot = 1'b0;
        chk("busy_drops",  256'(drops), 256'(1));
        chk("busy_stable", 256'(hdr_bad), 256'(0));
        req = 4'b0000;
        pkt_ready = 1'b1;
        step();
        pkt_ready = 1'b0;
        gcount = 0;
        for (int c = 0; c < 4; c++) begin
            if (grant == 4'b0010) gcount++;
            else if (grant != 4'b0000) gcount += 10;
            step();
        end
        chk("busy_grants", 256'(gcount), 256'(1));

`ifdef H14TX_PKT_SCHED_MISS_EN
        // src3 still armed from the last frame and requesting
        chk("miss_pre", 256'(miss), 256'(4'b0000));
        req = 4'b1000;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("miss_set", 256'(miss), 256'(4'b1000));
        slot_txn("miss_grant", 3);
        chk("miss_sticky", 256'(miss), 256'(4'b1000));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("miss_rst", 256'(miss), 256'(4'b0000));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
